// File: rtl/float_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : float_pkg
//  Description : Shared constants and FSM encoding for the float divider.
//  Revision    : 1.0 - initial release
// ============================================================================
package float_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SPECIAL = 3'd1;
    localparam logic [2:0] ST_DIVIDE  = 3'd2;
    localparam logic [2:0] ST_NORM    = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    localparam int          BIAS    = 127;
    localparam int          EXP_MAX = 255;
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam int          Q_W     = 26;

    localparam logic [1:0] OVF_NONE  = 2'b00;
    localparam logic [1:0] OVF_OVER  = 2'b01;
    localparam logic [1:0] OVF_UNDER = 2'b10;

endpackage
`default_nettype wire

// File: rtl/float_div_mant_div.sv
`default_nettype none
// ============================================================================
//  Module      : mant_div
//  Description : Bit-serial restoring divider, ({1,a} << 25) / {1,b}.
//  Revision    : 1.0 - initial release
// ============================================================================
module mant_div
    import float_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           i_start,
    input  logic [22:0]    i_man_a,
    input  logic [22:0]    i_man_b,
    output logic           o_done,
    output logic [Q_W-1:0] o_quot
);

    localparam logic [4:0] c_last = 5'(Q_W - 1);

    logic           r_run;
    logic [4:0]     r_cnt;
    logic [24:0]    r_rem;
    logic [23:0]    r_dvs;
    logic [Q_W-1:0] r_quot;
    logic           w_ge;
    logic [24:0]    w_diff;

    // Remainder stays below the divisor, so the shifted value fits in 25 bits.
    assign w_ge   = (r_rem >= {1'b0, r_dvs});
    assign w_diff = w_ge ? (r_rem - {1'b0, r_dvs}) : r_rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_run  <= 1'b0;
            r_cnt  <= 5'd0;
            r_rem  <= 25'd0;
            r_dvs  <= 24'd0;
            r_quot <= '0;
        end else if (i_start) begin
            r_run  <= 1'b1;
            r_cnt  <= 5'd0;
            r_rem  <= {2'b01, i_man_a};
            r_dvs  <= {1'b1, i_man_b};
            r_quot <= '0;
        end else if (r_run) begin
            r_quot <= {r_quot[Q_W-2:0], w_ge};
            r_rem  <= {w_diff[23:0], 1'b0};
            if (r_cnt == c_last) begin
                r_run <= 1'b0;
                r_cnt <= 5'd0;
            end else begin
                r_cnt <= r_cnt + 5'd1;
            end
        end
    end

    // Flags the cycle whose closing edge produces the final quotient bit.
    assign o_done = r_run && (r_cnt == c_last);
    assign o_quot = r_quot;

endmodule
`default_nettype wire

// File: rtl/float_div.sv
`default_nettype none
// ============================================================================
//  Module      : float_div
//  Description : Multi-cycle IEEE-754 single-precision divider with
//                special-case handling, normalisation and optional rounding.
//  Revision    : 1.0 - initial release
// ============================================================================
module float_div
    import float_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        round_cfg,
    input  logic [31:0] flout_a,
    input  logic [31:0] flout_b,
    output logic [31:0] flout_c,
    output logic [1:0]  overflow,
    output logic        div_zero,
    output logic        busy,
    output logic        done
);

    logic [2:0]     r_state;
    logic [2:0]     w_next;
    logic [31:0]    r_a;
    logic [31:0]    r_b;
    logic           r_rnd;
    logic [31:0]    r_res;
    logic [1:0]     r_res_ovf;
    logic           r_res_dz;

    logic           w_latch;
    logic           w_div_start;
    logic           w_ld_sp;
    logic           w_ld_nm;
    logic           w_fin;
    logic           w_div_done;
    logic [Q_W-1:0] w_quot;

    logic           w_sign;
    logic [7:0]     w_ea;
    logic [7:0]     w_eb;
    logic           w_a_zero;
    logic           w_b_zero;
    logic           w_a_ff;
    logic           w_b_ff;
    logic           w_special;
    logic [31:0]    w_sp_res;
    logic           w_sp_dz;

    logic signed [9:0] w_exp_raw;
    logic signed [9:0] w_exp;
    logic signed [9:0] w_exp_fin;
    logic [22:0]       w_mant;
    logic              w_guard;
    logic [23:0]       w_mant_rnd;
    logic [22:0]       w_mant_fin;
    logic [31:0]       w_nm_res;
    logic [1:0]        w_nm_ovf;

    assign w_sign    = r_a[31] ^ r_b[31];
    assign w_ea      = r_a[30:23];
    assign w_eb      = r_b[30:23];
    assign w_a_zero  = (w_ea == 8'h00);
    assign w_b_zero  = (w_eb == 8'h00);
    assign w_a_ff    = (w_ea == 8'hFF);
    assign w_b_ff    = (w_eb == 8'hFF);
    assign w_special = w_a_ff | w_b_ff | w_a_zero | w_b_zero;

    always_comb begin
        w_sp_res = 32'd0;
        w_sp_dz  = 1'b0;
        if (w_a_ff || w_b_ff) begin
            w_sp_res = QNAN;
        end else if (w_a_zero && w_b_zero) begin
            w_sp_res = QNAN;
            w_sp_dz  = 1'b1;
        end else if (w_b_zero) begin
            w_sp_res = {w_sign, 8'hFF, 23'd0};
            w_sp_dz  = 1'b1;
        end
    end

    mant_div u_mant_div (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_div_start),
        .i_man_a (r_a[22:0]),
        .i_man_b (r_b[22:0]),
        .o_done  (w_div_done),
        .o_quot  (w_quot)
    );

    assign w_exp_raw = $signed({2'b00, w_ea} - {2'b00, w_eb} + 10'(BIAS));

    always_comb begin
        w_mant  = w_quot[23:1];
        w_guard = w_quot[0];
        w_exp   = w_exp_raw - 10'sd1;
        if (w_quot[Q_W-1]) begin
            w_mant  = w_quot[24:2];
            w_guard = w_quot[1];
            w_exp   = w_exp_raw;
        end
        w_mant_rnd = {1'b0, w_mant};
        if (r_rnd && w_guard) begin
            w_mant_rnd = {1'b0, w_mant} + 24'd1;
        end
        // A rounding carry wraps the mantissa to zero and bumps the exponent.
        w_mant_fin = w_mant_rnd[22:0];
        w_exp_fin  = w_mant_rnd[23] ? (w_exp + 10'sd1) : w_exp;

        w_nm_res = {w_sign, w_exp_fin[7:0], w_mant_fin};
        w_nm_ovf = OVF_NONE;
        if (w_exp_fin >= $signed(10'(EXP_MAX))) begin
            w_nm_res = {w_sign, 8'hFF, 23'd0};
            w_nm_ovf = OVF_OVER;
        end else if (w_exp_fin <= 10'sd0) begin
            w_nm_res = 32'd0;
            w_nm_ovf = OVF_UNDER;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (en) w_next = ST_SPECIAL;
            ST_SPECIAL: w_next = w_special ? ST_DONE : ST_DIVIDE;
            ST_DIVIDE:  if (w_div_done) w_next = ST_NORM;
            ST_NORM:    w_next = ST_DONE;
            ST_DONE:    w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_latch     = (r_state == ST_IDLE) && en;
        w_div_start = (r_state == ST_SPECIAL) && !w_special;
        w_ld_sp     = (r_state == ST_SPECIAL) && w_special;
        w_ld_nm     = (r_state == ST_NORM);
        w_fin       = (r_state == ST_DONE);
    end

    assign busy = (r_state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a       <= 32'd0;
            r_b       <= 32'd0;
            r_rnd     <= 1'b0;
            r_res     <= 32'd0;
            r_res_ovf <= OVF_NONE;
            r_res_dz  <= 1'b0;
            flout_c   <= 32'd0;
            overflow  <= OVF_NONE;
            div_zero  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= w_fin;
            if (w_latch) begin
                r_a   <= flout_a;
                r_b   <= flout_b;
                r_rnd <= round_cfg;
            end
            if (w_ld_sp) begin
                r_res     <= w_sp_res;
                r_res_ovf <= OVF_NONE;
                r_res_dz  <= w_sp_dz;
            end
            if (w_ld_nm) begin
                r_res     <= w_nm_res;
                r_res_ovf <= w_nm_ovf;
                r_res_dz  <= 1'b0;
            end
            if (w_fin) begin
                flout_c  <= r_res;
                overflow <= r_res_ovf;
                div_zero <= r_res_dz;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_float_div.sv
`default_nettype none
// ============================================================================
//  Module      : tb_float_div
//  Description : Directed self-checking bench for float_div.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_float_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        round_cfg;
    logic [31:0] flout_a;
    logic [31:0] flout_b;
    logic [31:0] flout_c;
    logic [1:0]  overflow;
    logic        div_zero;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    float_div dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .round_cfg (round_cfg),
        .flout_a   (flout_a),
        .flout_b   (flout_b),
        .flout_c   (flout_c),
        .overflow  (overflow),
        .div_zero  (div_zero),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic cfg);
        @(negedge clk);
        flout_a   = a;
        flout_b   = b;
        round_cfg = cfg;
        en        = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic cfg, input logic [31:0] exp_c, input logic [1:0] exp_ovf,
                          input logic exp_dz, input int exp_lat);
        int lat;
        start_op(a, b, cfg);
        wait_done(lat);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " flout_c"}, flout_c, exp_c);
        check({tag, " overflow"}, {30'd0, overflow}, {30'd0, exp_ovf});
        check({tag, " div_zero"}, {31'd0, div_zero}, {31'd0, exp_dz});
        @(posedge clk);
        #1;
        check({tag, " done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int n_done;
        int first;
        int busy_gap;

        rst       = 1'b1;
        en        = 1'b0;
        round_cfg = 1'b0;
        flout_a   = 32'd0;
        flout_b   = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset flout_c",  flout_c, 32'd0);
        check("reset overflow", {30'd0, overflow}, 32'd0);
        check("reset div_zero", {31'd0, div_zero}, 32'd0);
        check("reset done",     {31'd0, done}, 32'd0);
        check("reset busy",     {31'd0, busy}, 32'd0);
        rst = 1'b0;

        run_op("6/2 rnd",      32'h40C0_0000, 32'h4000_0000, 1'b1, 32'h4040_0000, 2'b00, 1'b0, 29);
        run_op("1/3 rnd",      32'h3F80_0000, 32'h4040_0000, 1'b1, 32'h3EAA_AAAB, 2'b00, 1'b0, 29);
        run_op("1/3 chop",     32'h3F80_0000, 32'h4040_0000, 1'b0, 32'h3EAA_AAAA, 2'b00, 1'b0, 29);
        run_op("3/2.5 rnd",    32'h4040_0000, 32'h4020_0000, 1'b1, 32'h3F99_999A, 2'b00, 1'b0, 29);
        run_op("3/2.5 chop",   32'h4040_0000, 32'h4020_0000, 1'b0, 32'h3F99_9999, 2'b00, 1'b0, 29);
        run_op("-6/2",         32'hC0C0_0000, 32'h4000_0000, 1'b1, 32'hC040_0000, 2'b00, 1'b0, 29);
        run_op("1/0",          32'h3F80_0000, 32'h0000_0000, 1'b1, 32'h7F80_0000, 2'b00, 1'b1, 2);
        run_op("-1/0",         32'hBF80_0000, 32'h0000_0000, 1'b0, 32'hFF80_0000, 2'b00, 1'b1, 2);
        run_op("0/0",          32'h0000_0000, 32'h0000_0000, 1'b1, 32'h7FC0_0000, 2'b00, 1'b1, 2);
        run_op("inf/1",        32'h7F80_0000, 32'h3F80_0000, 1'b1, 32'h7FC0_0000, 2'b00, 1'b0, 2);
        run_op("0/1",          32'h0000_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000, 2'b00, 1'b0, 2);
        run_op("underflow",    32'h0080_0000, 32'h7F00_0000, 1'b1, 32'h0000_0000, 2'b10, 1'b0, 29);

        // Second en mid-operation must be ignored.
        start_op(32'h40C0_0000, 32'h4000_0000, 1'b1);
        n_done   = 0;
        first    = 0;
        busy_gap = 0;
        for (int n = 1; n <= 40; n++) begin
            if (n == 10) begin
                @(negedge clk);
                flout_a   = 32'h3F80_0000;
                flout_b   = 32'h4040_0000;
                round_cfg = 1'b0;
                en        = 1'b1;
            end
            @(posedge clk);
            #1;
            en = 1'b0;
            if (done) begin
                n_done++;
                if (first == 0) first = n;
            end
            if (first == 0 && !busy) busy_gap++;
        end
        check("ignore_en done count", 32'(n_done), 32'd1);
        check("ignore_en latency",    32'(first), 32'd29);
        check("ignore_en busy gaps",  32'(busy_gap), 32'd0);
        check("ignore_en flout_c",    flout_c, 32'h4040_0000);

        run_op("overflow",     32'h7F00_0000, 32'h0080_0000, 1'b1, 32'h7F80_0000, 2'b01, 1'b0, 29);

        // Reset mid-operation aborts without a done pulse.
        start_op(32'h3F80_0000, 32'h4040_0000, 1'b1);
        for (int n = 1; n <= 15; n++) begin
            if (n == 15) begin
                @(negedge clk);
                rst = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        check("abort flout_c",  flout_c, 32'd0);
        check("abort overflow", {30'd0, overflow}, 32'd0);
        check("abort div_zero", {31'd0, div_zero}, 32'd0);
        check("abort done",     {31'd0, done}, 32'd0);
        check("abort busy",     {31'd0, busy}, 32'd0);
        rst    = 1'b0;
        n_done = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (done) n_done++;
        end
        check("abort no done", 32'(n_done), 32'd0);

        run_op("after abort",  32'h40C0_0000, 32'h4000_0000, 1'b1, 32'h4040_0000, 2'b00, 1'b0, 29);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/float_div.md
FLOAT_DIV -- requirements
Module: float_div

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port en, input, 1 bit: start pulse; sampled only while idle.
REQ-004 SHALL have port round_cfg, input, 1 bit: 0 = chopping, 1 = round-to-nearest on the guard bit; sampled with en.
REQ-005 SHALL have port flout_a, input, 32 bits: IEEE-754 single-precision dividend.
REQ-006 SHALL have port flout_b, input, 32 bits: IEEE-754 single-precision divisor.
REQ-007 SHALL have port flout_c, output reg, 32 bits: quotient.
REQ-008 SHALL have port overflow, output reg, 2 bits: 00 none, 01 exponent overflow, 10 exponent underflow.
REQ-009 SHALL have port div_zero, output reg, 1 bit: divisor was zero.
REQ-010 SHALL have port busy, output, 1 bit: high from the edge after en is accepted until done.
REQ-011 SHALL have port done, output reg, 1 bit: one-cycle pulse; flout_c, overflow and div_zero are valid from this cycle.

Function
REQ-012 SHALL implement FSM states IDLE, SPECIAL, DIVIDE, NORM, DONE; en in IDLE latches operands and round_cfg, then enters SPECIAL.
REQ-013 SHALL ignore en in every non-IDLE state; latched operands SHALL not change mid-operation.
REQ-014 SHALL treat exponent 0 as zero (denormals flushed) and exponent FF as Inf/NaN.
REQ-015 In SPECIAL, an FF exponent on either operand, or both operands zero, SHALL give 7FC00000; only the both-zero case also sets div_zero=1.
REQ-016 In SPECIAL, b zero with a nonzero and finite SHALL give {sign,FF,0} with div_zero=1.
REQ-017 In SPECIAL, a zero with b nonzero and finite SHALL give 00000000.
REQ-018 Every SPECIAL case SHALL go directly to DONE; all other cases SHALL enter DIVIDE.
REQ-019 Sign SHALL be a[31] XOR b[31].
REQ-020 DIVIDE SHALL run a restoring division of {1,ma}<<25 by {1,mb}, one quotient bit per cycle for exactly 26 cycles, counted by a 5-bit counter, giving q[25:0] with q in [2^24, 2^26).
REQ-021 NORM SHALL form a 10-bit signed exponent e = ea - eb + 127.
REQ-022 If q[25]=1, NORM SHALL take mantissa q[24:2] and guard bit q[1].
REQ-023 If q[25]=0, NORM SHALL take mantissa q[23:1], guard bit q[0], and use e-1.
REQ-024 If round_cfg=1 and the guard bit is 1, NORM SHALL add 1 to the mantissa; a carry-out SHALL clear the mantissa and increment e.
REQ-025 If final e >= 255, the result SHALL be {sign,FF,0} with overflow=01.
REQ-026 If final e <= 0, the result SHALL be 00000000 with overflow=10.
REQ-027 Otherwise the result SHALL be {sign, e[7:0], mantissa} with overflow=00.
REQ-028 Latency: done SHALL assert 29 edges after the en-sampling edge for normal operands and 2 edges after it for special operands.
REQ-029 flout_c, overflow and div_zero SHALL hold until the next done.
REQ-030 DONE SHALL return to IDLE on the next edge; en may be accepted on the edge after done.

Reset
REQ-031 rst SHALL force IDLE with flout_c=0, overflow=00, div_zero=0, done=0, busy=0 and the counter at 0.
REQ-032 rst asserted mid-operation SHALL abort the operation; no done pulse SHALL follow.

Structure
REQ-033 Package float_pkg SHALL hold the FSM state encoding, BIAS=127, EXP_MAX=255, QNAN=32'h7FC00000, and the quotient width of 26.
REQ-034 The restoring mantissa divider SHALL be sub-module mant_div, with start/done handshake and a 26-bit quotient output; FSM, specials and normalization SHALL reside in float_div.

Verification
REQ-035 40C00000 / 40000000, round_cfg=1 -> flout_c=40400000, overflow=00, done at edge 29.
REQ-036 3F800000 / 40400000 -> round_cfg=1 gives 3EAAAAAB; round_cfg=0 gives 3EAAAAAA.
REQ-037 3F800000 / 00000000 -> 7F800000 with div_zero=1, done at edge 2; 00000000 / 00000000 -> 7FC00000 with div_zero=1.
REQ-038 7F000000 / 00800000 -> 7F800000 with overflow=01; 00800000 / 7F000000 -> 00000000 with overflow=10.
REQ-039 en pulsed again at edge 10 with different operands -> ignored; first result unchanged, busy continuous, single done.
REQ-040 rst at edge 15 of an operation -> all outputs 0 next edge, no done; a new en afterwards completes normally.
